// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD stopwatch counter (mm:ss.cc) with IDLE/RUN/PAUSE control.
//
// Parameters:
//   c_min_lim     minutes roll-over limit (2..100)
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset
//   incr_i        10 ms tick (single-cycle pulse)
//   start_stop_i  start/stop command pulse
//   clear_i       clear command pulse (wins over start_stop_i)
//   cs_o          centiseconds, two BCD digits
//   sec_o         seconds, two BCD digits
//   min_o         minutes, two BCD digits
//   running_o     high in RUN
//   ovf_o         sticky: minutes wrapped at least once
// Optional feature (macro STOPWATCH_LAP_EN):
//   lap_i         lap capture pulse, honoured in RUN
//   lap_cs_o, lap_sec_o, lap_min_o  captured BCD time
//   lap_valid_o   a capture exists
module stopwatch_core #(
  parameter int unsigned c_min_lim = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       incr_i,
  input  logic       start_stop_i,
  input  logic       clear_i,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap_i,
  output logic [7:0] lap_cs_o,
  output logic [7:0] lap_sec_o,
  output logic [7:0] lap_min_o,
  output logic       lap_valid_o,
`endif
  output logic [7:0] cs_o,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic       running_o,
  output logic       ovf_o
);

  localparam logic [7:0] MIN_LAST = {4'((c_min_lim - 1) / 10), 4'((c_min_lim - 1) % 10)};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cs;
  logic [7:0] r_sec;
  logic [7:0] r_min;
  logic       r_ovf;
  logic [7:0] w_nxt_cs;
  logic [7:0] w_nxt_sec;
  logic [7:0] w_nxt_min;
  logic       w_wrap;
  logic       w_cnt_en;
  logic       w_running;

  // Ticks count on the current state, so a tick alongside RUN->PAUSE is
  // counted and one alongside IDLE/PAUSE->RUN is not.
  assign w_cnt_en = (r_state == RUN) && incr_i && !clear_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = IDLE;
    end else if (start_stop_i) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_running = (r_state == RUN);
  end

  // Next count with the whole carry chain resolved in one cycle; equals the
  // current count when not counting.
  always_comb begin
    w_nxt_cs  = r_cs;
    w_nxt_sec = r_sec;
    w_nxt_min = r_min;
    w_wrap    = 1'b0;
    if (w_cnt_en) begin
      if (r_cs[3:0] != 4'd9) begin
        w_nxt_cs[3:0] = r_cs[3:0] + 4'd1;
      end else begin
        w_nxt_cs[3:0] = '0;
        if (r_cs[7:4] != 4'd9) begin
          w_nxt_cs[7:4] = r_cs[7:4] + 4'd1;
        end else begin
          w_nxt_cs[7:4] = '0;
          if (r_sec[3:0] != 4'd9) begin
            w_nxt_sec[3:0] = r_sec[3:0] + 4'd1;
          end else begin
            w_nxt_sec[3:0] = '0;
            if (r_sec[7:4] != 4'd5) begin
              w_nxt_sec[7:4] = r_sec[7:4] + 4'd1;
            end else begin
              w_nxt_sec[7:4] = '0;
              if (r_min == MIN_LAST) begin
                w_nxt_min = '0;
                w_wrap    = 1'b1;
              end else if (r_min[3:0] != 4'd9) begin
                w_nxt_min[3:0] = r_min[3:0] + 4'd1;
              end else begin
                w_nxt_min[3:0] = '0;
                w_nxt_min[7:4] = r_min[7:4] + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cs  <= '0;
      r_sec <= '0;
      r_min <= '0;
      r_ovf <= 1'b0;
    end else if (clear_i) begin
      r_cs  <= '0;
      r_sec <= '0;
      r_min <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cs  <= w_nxt_cs;
      r_sec <= w_nxt_sec;
      r_min <= w_nxt_min;
      r_ovf <= r_ovf | w_wrap;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [7:0] r_lap_cs;
  logic [7:0] r_lap_sec;
  logic [7:0] r_lap_min;
  logic       r_lap_valid;

  // Capture the post-edge count so a same-edge tick is included.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lap_cs    <= '0;
      r_lap_sec   <= '0;
      r_lap_min   <= '0;
      r_lap_valid <= 1'b0;
    end else if (clear_i) begin
      r_lap_cs    <= '0;
      r_lap_sec   <= '0;
      r_lap_min   <= '0;
      r_lap_valid <= 1'b0;
    end else if (lap_i && (r_state == RUN)) begin
      r_lap_cs    <= w_nxt_cs;
      r_lap_sec   <= w_nxt_sec;
      r_lap_min   <= w_nxt_min;
      r_lap_valid <= 1'b1;
    end
  end

  assign lap_cs_o    = r_lap_cs;
  assign lap_sec_o   = r_lap_sec;
  assign lap_min_o   = r_lap_min;
  assign lap_valid_o = r_lap_valid;
`endif

  assign cs_o      = r_cs;
  assign sec_o     = r_sec;
  assign min_o     = r_min;
  assign ovf_o     = r_ovf;
  assign running_o = w_running;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: scoreboard bench for stopwatch_core. A behavioural model
// (total centiseconds, converted to BCD) pushes expected outputs per driven
// cycle; the DUT outputs sampled after each edge are compared in each test.
module tb_stopwatch_core;

  localparam int unsigned LIM = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       incr;
  logic       ss;
  logic       clr;
  logic [7:0] cs_o;
  logic [7:0] sec_o;
  logic [7:0] min_o;
  logic       running_o;
  logic       ovf_o;
`ifdef STOPWATCH_LAP_EN
  logic       lap;
  logic [7:0] lap_cs_o;
  logic [7:0] lap_sec_o;
  logic [7:0] lap_min_o;
  logic       lap_valid_o;
`endif

  always #5 clk = ~clk;

  stopwatch_core #(.c_min_lim(LIM)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .incr_i       (incr),
    .start_stop_i (ss),
    .clear_i      (clr),
`ifdef STOPWATCH_LAP_EN
    .lap_i        (lap),
    .lap_cs_o     (lap_cs_o),
    .lap_sec_o    (lap_sec_o),
    .lap_min_o    (lap_min_o),
    .lap_valid_o  (lap_valid_o),
`endif
    .cs_o         (cs_o),
    .sec_o        (sec_o),
    .min_o        (min_o),
    .running_o    (running_o),
    .ovf_o        (ovf_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // {cs[25:18], sec[17:10], min[9:2], running[1], ovf[0]}
  logic [25:0] exp_q[$];
  logic [25:0] act_q[$];

  int   m_total = 0;  // centiseconds since zero
  int   m_state = 0;  // 0 idle, 1 run, 2 pause
  logic m_ovf   = 1'b0;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [25:0] model_vec();
    return {bcd(m_total % 100), bcd((m_total / 100) % 60), bcd(m_total / 6000),
            (m_state == 1), m_ovf};
  endfunction

  function automatic string fmt(input logic [25:0] v);
    return $sformatf("%h:%h.%h run=%b ovf=%b", v[9:2], v[17:10], v[25:18], v[1], v[0]);
  endfunction

  function automatic logic [25:0] dut_vec();
    return {cs_o, sec_o, min_o, running_o, ovf_o};
  endfunction

  task automatic model_reset();
    m_total = 0;
    m_state = 0;
    m_ovf   = 1'b0;
  endtask

  // Drive one cycle, push the model's expectation, then sample the DUT.
  task automatic drive(input logic s, input logic c, input logic i);
    ss   = s;
    clr  = c;
    incr = i;
    if (c) begin
      model_reset();
    end else begin
      if (m_state == 1 && i) begin
        m_total++;
        if (m_total == int'(LIM) * 6000) begin
          m_total = 0;
          m_ovf   = 1'b1;
        end
      end
      if (s) m_state = (m_state == 1) ? 2 : 1;
    end
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    ss   = 1'b0;
    clr  = 1'b0;
    incr = 1'b0;
    act_q.push_back(dut_vec());
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_vec() !== 26'h0) begin
      miscompares++;
      $display("FAIL reset: got %s want 00:00.00 run=0 ovf=0", fmt(dut_vec()));
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_count150();
    logic [25:0] e, a;
    drive(1'b1, 1'b0, 1'b0);
    ticks(150);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL count150: got %s want %s", fmt(a), fmt(e));
      end
    end
    vectors++;
    if ({cs_o, sec_o, min_o, running_o} !== {8'h50, 8'h01, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL count150_final: got %s want 00:01.50 run=1", fmt(dut_vec()));
    end
  endtask

  task automatic test_rollover();
    logic [25:0] e, a;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    ticks(5999);
    ticks(1);
    vectors++;
    if ({cs_o, sec_o, min_o} !== {8'h00, 8'h00, 8'h01}) begin
      miscompares++;
      $display("FAIL sec_to_min: got %s want 01:00.00", fmt(dut_vec()));
    end
    ticks(int'(LIM - 1) * 6000 - 1);
    vectors++;
    if ({cs_o, sec_o, min_o, ovf_o} !== {8'h99, 8'h59, bcd(int'(LIM) - 1), 1'b0}) begin
      miscompares++;
      $display("FAIL pre_wrap: got %s want last minute :59.99 ovf=0", fmt(dut_vec()));
    end
    ticks(1);
    vectors++;
    if ({cs_o, sec_o, min_o, running_o, ovf_o} !== {8'h00, 8'h00, 8'h00, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL wrap: got %s want 00:00.00 run=1 ovf=1", fmt(dut_vec()));
    end
    ticks(3);
    drive(1'b1, 1'b0, 1'b1);  // pause, tick counted
    ticks(4);                 // ignored, ovf sticky
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL rollover: got %s want %s", fmt(a), fmt(e));
      end
    end
  endtask

  task automatic test_clear();
    logic [25:0] e, a;
    drive(1'b1, 1'b0, 1'b0);  // resume, ovf still set
    ticks(300 - 4);
    vectors++;
    if ({cs_o, sec_o, min_o, ovf_o} !== {8'h00, 8'h03, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL pre_clear: got %s want 00:03.00 ovf=1", fmt(dut_vec()));
    end
    drive(1'b1, 1'b1, 1'b0);
    vectors++;
    if (dut_vec() !== 26'h0) begin
      miscompares++;
      $display("FAIL clear_wins: got %s want 00:00.00 run=0 ovf=0", fmt(dut_vec()));
    end
    ticks(5);  // idle: ignored
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL clear: got %s want %s", fmt(a), fmt(e));
      end
    end
  endtask

  task automatic test_pause();
    logic [25:0] e, a;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1 & 1'b0, 1'b1);  // IDLE->RUN, tick ignored
    ticks(10);
    drive(1'b1, 1'b0, 1'b1);
    vectors++;
    if ({cs_o, sec_o, min_o, running_o} !== {8'h11, 8'h00, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL pause_tick: got %s want 00:00.11 run=0", fmt(dut_vec()));
    end
    ticks(20);
    drive(1'b1, 1'b0, 1'b1);
    vectors++;
    if ({cs_o, sec_o, min_o, running_o} !== {8'h11, 8'h00, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL resume_tick: got %s want 00:00.11 run=1", fmt(dut_vec()));
    end
    ticks(2);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL pause: got %s want %s", fmt(a), fmt(e));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [25:0] e, a;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    ticks(1234);
    vectors++;
    if ({cs_o, sec_o, min_o} !== {8'h34, 8'h12, 8'h00}) begin
      miscompares++;
      $display("FAIL pre_reset: got %s want 00:12.34", fmt(dut_vec()));
    end
    #2;
    rst  = 1'b1;
    incr = 1'b1;
    #1;
    vectors++;
    if (dut_vec() !== 26'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %s want 00:00.00 run=0 ovf=0", fmt(dut_vec()));
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    ticks(3);                 // idle after reset: ignored
    drive(1'b1, 1'b0, 1'b0);  // first start_stop enters RUN
    ticks(2);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL async_reset_seq: got %s want %s", fmt(a), fmt(e));
      end
    end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    logic [25:0] e, a;
    drive(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({lap_cs_o, lap_sec_o, lap_min_o, lap_valid_o} !== 25'h0) begin
      miscompares++;
      $display("FAIL lap_clear: got %h:%h.%h v=%b want zeros", lap_min_o, lap_sec_o, lap_cs_o, lap_valid_o);
    end
    drive(1'b1, 1'b0, 1'b0);
    ticks(499);
    lap = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    lap = 1'b0;
    vectors++;
    if ({lap_cs_o, lap_sec_o, lap_min_o, lap_valid_o} !== {8'h00, 8'h05, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL lap_capture: got %h:%h.%h v=%b want 00:05.00 v=1", lap_min_o, lap_sec_o, lap_cs_o, lap_valid_o);
    end
    ticks(7);
    drive(1'b1, 1'b0, 1'b0);  // pause
    lap = 1'b1;
    drive(1'b0, 1'b0, 1'b1);  // lap outside RUN ignored
    lap = 1'b0;
    vectors++;
    if ({lap_cs_o, lap_sec_o, lap_min_o, lap_valid_o} !== {8'h00, 8'h05, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL lap_hold: got %h:%h.%h v=%b want 00:05.00 v=1", lap_min_o, lap_sec_o, lap_cs_o, lap_valid_o);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL lap_count: got %s want %s", fmt(a), fmt(e));
      end
    end
  endtask
`endif

  initial begin
    rst  = 1'b1;
    incr = 1'b0;
    ss   = 1'b0;
    clr  = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap  = 1'b0;
`endif
    test_reset();
    test_count150();
    test_rollover();
    test_clear();
    test_pause();
    test_async_reset();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
